// File: rtl/spi_ram_arbiter_if.sv
// spi_ram_arbiter_if
// Bundles the three buses around the SPI/RAM arbiter:
//   SPI side  : rx_data/rx_valid (commands in), tx_data/tx_valid (read data out)
//   Host side : host_req/we/addr/wdata (request in), host_gnt, host_rdata/host_rvalid
//   RAM side  : ram_en/we/addr/wdata (access out), ram_rdata (read data in)
//   Status    : spi_overrun (sticky drop flag), busy (arbiter FSM not idle)
// The slave modport is the arbiter's view; master is the surrounding system.
interface spi_ram_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic [9:0]           rx_data;
    logic                 rx_valid;
    logic [7:0]           tx_data;
    logic                 tx_valid;

    logic                 host_req;
    logic                 host_we;
    logic [ADDR_SIZE-1:0] host_addr;
    logic [7:0]           host_wdata;
    logic                 host_gnt;
    logic [7:0]           host_rdata;
    logic                 host_rvalid;

    logic                 ram_en;
    logic                 ram_we;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [7:0]           ram_wdata;
    logic [7:0]           ram_rdata;

    logic                 spi_overrun;
    logic                 busy;

    modport slave (
        input  rx_data, rx_valid,
        input  host_req, host_we, host_addr, host_wdata,
        input  ram_rdata,
        output tx_data, tx_valid,
        output host_gnt, host_rdata, host_rvalid,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output spi_overrun, busy
    );

    modport master (
        output rx_data, rx_valid,
        output host_req, host_we, host_addr, host_wdata,
        output ram_rdata,
        input  tx_data, tx_valid,
        input  host_gnt, host_rdata, host_rvalid,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  spi_overrun, busy
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
// Decodes the 10-bit SPI command stream, keeps the SPI write/read address
// registers and a one-entry SPI pending buffer, and shares a single-port RAM
// between SPI and an on-chip host with round-robin arbitration. Read data is
// returned to whichever requester issued the read.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - spi_ram_arbiter_if.slave (SPI, host, RAM and status signals)
// Parameters:
//   ADDR_SIZE - RAM address width, equal to the 8-bit SPI payload
//   SPI_FIRST - 1: SPI wins the first contention after reset, 0: host wins
// Optional build macro:
//   SPI_ADDR_AUTOINC_EN - when defined, every accepted SPI write/read command
//   post-increments its address register (wrapping at 2^ADDR_SIZE).
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter bit SPI_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    spi_ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    logic                 spi_pend;
    logic                 pend_we;
    logic [ADDR_SIZE-1:0] pend_addr;
    logic [7:0]           pend_wdata;

    logic                 op_we;
    logic                 owner_spi;
    logic                 last_spi;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [7:0]           ram_wdata;

    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic [7:0]           host_rdata;
    logic                 host_rvalid;
    logic                 spi_overrun;

    logic                 grant_spi;
    logic                 grant_host;
    logic                 enq_ok;
    logic [1:0]           opcode;

    assign opcode = bus.rx_data[9:8];

    // A new SPI data command fits if the buffer is empty or is being
    // drained by a grant in this very cycle.
    assign enq_ok = !spi_pend || grant_spi;

    // Next-state and grant decision. Under contention the requester that
    // did not win last time is granted, so grants strictly alternate.
    always_comb begin
        state_next = state;
        grant_spi  = 1'b0;
        grant_host = 1'b0;
        case (state)
            IDLE: begin
                if (spi_pend && (!bus.host_req || !last_spi)) begin
                    grant_spi = 1'b1;
                end else if (bus.host_req) begin
                    grant_host = 1'b1;
                end
                if (grant_spi || grant_host) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = op_we ? IDLE : RDATA;
            RDATA:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: latch the granted operation onto the RAM bus, capture read
    // data in RDATA for its owner, and maintain the SPI address registers
    // and pending entry. Enqueue is written after dequeue so that a command
    // arriving in the dequeue cycle refills the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr     <= '0;
            rd_addr     <= '0;
            spi_pend    <= 1'b0;
            pend_we     <= 1'b0;
            pend_addr   <= '0;
            pend_wdata  <= 8'h00;
            op_we       <= 1'b0;
            owner_spi   <= 1'b0;
            last_spi    <= ~SPI_FIRST;
            ram_addr    <= '0;
            ram_wdata   <= 8'h00;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            host_rdata  <= 8'h00;
            host_rvalid <= 1'b0;
            spi_overrun <= 1'b0;
        end else begin
            tx_valid    <= 1'b0;
            host_rvalid <= 1'b0;

            if (grant_spi) begin
                op_we     <= pend_we;
                ram_addr  <= pend_addr;
                ram_wdata <= pend_wdata;
                owner_spi <= 1'b1;
                last_spi  <= 1'b1;
                spi_pend  <= 1'b0;
            end else if (grant_host) begin
                op_we     <= bus.host_we;
                ram_addr  <= bus.host_addr;
                ram_wdata <= bus.host_wdata;
                owner_spi <= 1'b0;
                last_spi  <= 1'b0;
            end

            if (state == RDATA) begin
                if (owner_spi) begin
                    tx_data  <= bus.ram_rdata;
                    tx_valid <= 1'b1;
                end else begin
                    host_rdata  <= bus.ram_rdata;
                    host_rvalid <= 1'b1;
                end
            end

            if (bus.rx_valid) begin
                case (opcode)
                    2'b00: wr_addr <= bus.rx_data[7:0];
                    2'b10: rd_addr <= bus.rx_data[7:0];
                    2'b01: begin
                        if (enq_ok) begin
                            spi_pend   <= 1'b1;
                            pend_we    <= 1'b1;
                            pend_addr  <= wr_addr;
                            pend_wdata <= bus.rx_data[7:0];
`ifdef SPI_ADDR_AUTOINC_EN
                            wr_addr    <= wr_addr + 1'b1;
`endif
                        end else begin
                            spi_overrun <= 1'b1;
                        end
                    end
                    default: begin
                        if (enq_ok) begin
                            spi_pend   <= 1'b1;
                            pend_we    <= 1'b0;
                            pend_addr  <= rd_addr;
                            pend_wdata <= 8'h00;
`ifdef SPI_ADDR_AUTOINC_EN
                            rd_addr    <= rd_addr + 1'b1;
`endif
                        end else begin
                            spi_overrun <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // The RAM is only enabled in ACCESS; write enable is gated by it so it
    // never shows up on an idle bus.
    assign bus.ram_en      = (state == ACCESS);
    assign bus.ram_we      = (state == ACCESS) && op_we;
    assign bus.ram_addr    = ram_addr;
    assign bus.ram_wdata   = ram_wdata;
    assign bus.host_gnt    = (state == ACCESS) && !owner_spi;
    assign bus.tx_data     = tx_data;
    assign bus.tx_valid    = tx_valid;
    assign bus.host_rdata  = host_rdata;
    assign bus.host_rvalid = host_rvalid;
    assign bus.spi_overrun = spi_overrun;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter
// Self-checking bench for spi_ram_arbiter: directed scenarios followed by a
// randomized phase where SPI and host traffic run concurrently on disjoint
// address halves, checked against a plain memory-image reference model.
// Honours SPI_ADDR_AUTOINC_EN for its expectations.
module tb_spi_ram_arbiter;

    localparam int ADDR_SIZE = 8;

    logic clk = 1'b0;
    logic rst;
    logic ram_clear;

    always #5 clk = ~clk;

    spi_ram_arbiter_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

    spi_ram_arbiter #(
        .ADDR_SIZE(ADDR_SIZE),
        .SPI_FIRST(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];

    int checks  = 0;
    int errors  = 0;
    int we_viol = 0;

    int         lat;
    logic [7:0] dat;
    int         g_lat;
    int         r_lat;
    int         n_acc;
    int         g_idx;
    int         bad;
    logic [7:0] acc_addr [2];

    logic [7:0] spi_a;
    logic [7:0] spi_d;
    int         spi_lat;
    logic [7:0] spi_rd;
    logic [7:0] host_a;
    logic [7:0] host_d;
    logic       host_w;
    int         host_g;
    int         host_r;
    logic [7:0] host_rd;

    // Synchronous single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            bus.ram_rdata <= 8'h00;
        end else begin
            if (bus.ram_en && bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= ram[bus.ram_addr];
        end
    end

    // Write enable must never be seen without enable.
    always @(negedge clk) begin
        if (bus.ram_we && !bus.ram_en) we_viol++;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] cmd);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = cmd;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic waitTx(input int budget, output int l, output logic [7:0] d);
        l = 0;
        d = 8'h00;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.tx_valid) begin
                l = i;
                d = bus.tx_data;
                break;
            end
        end
    endtask

    task automatic hostOp(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input int budget, output int gl, output int rl, output logic [7:0] rd);
        @(posedge clk);
        #1;
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = addr;
        bus.host_wdata = wdata;
        gl = 0;
        rl = 0;
        rd = 8'h00;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (gl != 0 && bus.host_rvalid) begin
                rl = i;
                rd = bus.host_rdata;
                break;
            end
            if (gl == 0 && bus.host_gnt) begin
                gl = i;
                @(posedge clk);
                #1 bus.host_req = 1'b0;
                if (we) break;
            end
        end
        bus.host_req = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        ram_clear      = 1'b1;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 10'h000;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = 8'h00;
        bus.host_wdata = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1 ram_clear = 1'b0;
        @(negedge clk);
        checkOutput("rst_tx_valid",    bus.tx_valid, 0);
        checkOutput("rst_tx_data",     bus.tx_data, 0);
        checkOutput("rst_host_gnt",    bus.host_gnt, 0);
        checkOutput("rst_host_rdata",  bus.host_rdata, 0);
        checkOutput("rst_host_rvalid", bus.host_rvalid, 0);
        checkOutput("rst_ram_en",      bus.ram_en, 0);
        checkOutput("rst_ram_we",      bus.ram_we, 0);
        checkOutput("rst_ram_addr",    bus.ram_addr, 0);
        checkOutput("rst_ram_wdata",   bus.ram_wdata, 0);
        checkOutput("rst_overrun",     bus.spi_overrun, 0);
        checkOutput("rst_busy",        bus.busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // SPI write then SPI read of the same location
        applyStimulus(10'h005);
        waitCycles(10);
        applyStimulus(10'h1A5);
        waitCycles(10);
        checkOutput("spi_wr_ram05", ram[8'h05], 8'hA5);
        applyStimulus(10'h205);
        waitCycles(10);
        applyStimulus(10'h300);
        waitTx(8, lat, dat);
        checkOutput("spi_rd_latency", lat, 4);
        checkOutput("spi_rd_data", dat, 8'hA5);
        waitCycles(2);

        // Host write then host read
        hostOp(1'b1, 8'h10, 8'h3C, 10, g_lat, r_lat, dat);
        checkOutput("host_wr_gnt_lat", g_lat, 2);
        waitCycles(2);
        checkOutput("host_wr_ram10", ram[8'h10], 8'h3C);
        hostOp(1'b0, 8'h10, 8'h00, 10, g_lat, r_lat, dat);
        checkOutput("host_rd_gnt_lat", g_lat, 2);
        checkOutput("host_rd_rvalid_lat", r_lat, 4);
        checkOutput("host_rd_data", dat, 8'h3C);
        waitCycles(2);

        // Contention right after reset: SPI must win first
        pulseReset();
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 10'h1FF;
        @(posedge clk);
        #1;
        bus.rx_valid   = 1'b0;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 8'h20;
        bus.host_wdata = 8'h77;
        n_acc = 0;
        g_idx = 0;
        acc_addr[0] = 8'hEE;
        acc_addr[1] = 8'hEE;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.ram_en) begin
                if (n_acc < 2) acc_addr[n_acc] = bus.ram_addr;
                n_acc++;
            end
            if (bus.host_gnt && g_idx == 0) begin
                g_idx = i;
                @(posedge clk);
                #1 bus.host_req = 1'b0;
            end
        end
        bus.host_req = 1'b0;
        checkOutput("cont_num_access", n_acc, 2);
        checkOutput("cont_first_addr", acc_addr[0], 8'h00);
        checkOutput("cont_second_addr", acc_addr[1], 8'h20);
        checkOutput("cont_host_gnt_idx", g_idx, 4);
        checkOutput("cont_ram00", ram[8'h00], 8'hFF);
        checkOutput("cont_ram20", ram[8'h20], 8'h77);

        // Overrun: two SPI writes back to back while a host read is in flight
        applyStimulus(10'h040);
        waitCycles(3);
        @(posedge clk);
        #1;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b0;
        bus.host_addr  = 8'h10;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 10'h111;
        @(negedge clk);
        checkOutput("ovr_host_gnt", bus.host_gnt, 1);
        @(posedge clk);
        #1;
        bus.rx_data  = 10'h122;
        bus.host_req = 1'b0;
        @(negedge clk);
        checkOutput("ovr_rdata_ram_en", bus.ram_en, 0);
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        @(negedge clk);
        checkOutput("ovr_host_rvalid", bus.host_rvalid, 1);
        checkOutput("ovr_host_rdata", bus.host_rdata, 8'h3C);
        checkOutput("ovr_flag_set", bus.spi_overrun, 1);
        waitCycles(10);
        checkOutput("ovr_flag_sticky", bus.spi_overrun, 1);
        checkOutput("ovr_ram40", ram[8'h40], 8'h11);
        checkOutput("ovr_ram41", ram[8'h41], 8'h00);

        // Reset during RDATA of an SPI read aborts it
        applyStimulus(10'h205);
        waitCycles(3);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 10'h300;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_in_rdata_busy", bus.busy, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_tx_valid", bus.tx_valid, 0);
        checkOutput("abort_tx_data", bus.tx_data, 0);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_overrun_cleared", bus.spi_overrun, 0);
        checkOutput("abort_ram_en", bus.ram_en, 0);
        waitTx(6, lat, dat);
        checkOutput("abort_no_tx", lat, 0);
        applyStimulus(10'h205);
        waitCycles(3);
        applyStimulus(10'h300);
        waitTx(8, lat, dat);
        checkOutput("post_abort_rd_lat", lat, 4);
        checkOutput("post_abort_rd_data", dat, 8'hA5);
        waitCycles(2);

        // Address wrap with optional auto-increment
        applyStimulus(10'h0FF);
        waitCycles(3);
        applyStimulus(10'h111);
        waitCycles(8);
        applyStimulus(10'h122);
        waitCycles(8);
`ifdef SPI_ADDR_AUTOINC_EN
        checkOutput("inc_ramFF", ram[8'hFF], 8'h11);
        checkOutput("inc_ram00", ram[8'h00], 8'h22);
`else
        checkOutput("noinc_ramFF", ram[8'hFF], 8'h22);
        checkOutput("noinc_ram00", ram[8'h00], 8'hFF);
`endif

        // Randomized concurrent traffic: SPI in 0x80-0xFF, host in 0x00-0x7F
        pulseReset();
        for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    spi_a = 8'h80 | 8'($urandom_range(0, 127));
                    spi_d = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 1) == 1) begin
                        applyStimulus({2'b00, spi_a});
                        waitCycles(2);
                        applyStimulus({2'b01, spi_d});
                        ref_mem[spi_a] = spi_d;
                        waitCycles(8);
                    end else begin
                        applyStimulus({2'b10, spi_a});
                        waitCycles(2);
                        applyStimulus(10'h300);
                        waitTx(15, spi_lat, spi_rd);
                        checkOutput("rnd_spi_rd_lat_ok", (spi_lat >= 4 && spi_lat <= 10), 1);
                        checkOutput("rnd_spi_rd_data", spi_rd, ref_mem[spi_a]);
                        waitCycles(3);
                    end
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    host_a = 8'($urandom_range(0, 127));
                    host_d = 8'($urandom_range(0, 255));
                    host_w = 1'($urandom_range(0, 1));
                    hostOp(host_w, host_a, host_d, 20, host_g, host_r, host_rd);
                    checkOutput("rnd_host_gnt_ok", (host_g >= 2 && host_g <= 6), 1);
                    if (host_w) begin
                        ref_mem[host_a] = host_d;
                    end else begin
                        checkOutput("rnd_host_rvalid_lat", host_r, host_g + 2);
                        checkOutput("rnd_host_rd_data", host_rd, ref_mem[host_a]);
                    end
                    waitCycles($urandom_range(0, 3));
                end
            end
        join
        waitCycles(5);
        checkOutput("rnd_no_overrun", bus.spi_overrun, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== ref_mem[i]) bad++;
        end
        checkOutput("rnd_mem_image", bad, 0);
        checkOutput("ram_we_without_en", we_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
